// File: rtl/cv32e40p_obi_data_responder.sv
// OBI data-memory responder: word RAM behind data_req/gnt/rvalid with grant stall,
// outstanding limit and fixed-latency in-order responses. Optional: CV32E40P_OBI_RESP_ERR_EN.
module cv32e40p_obi_data_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned GNT_DELAY       = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o
`ifdef CV32E40P_OBI_RESP_ERR_EN
    ,
    output logic        data_err_o
`endif
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [3:0]       LAT_INIT = 4'(RESP_LATENCY - 1);
    localparam logic [3:0]       DELAY    = 4'(GNT_DELAY);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [3:0]       fifo_cnt_q   [MAX_OUTSTANDING];
    logic [3:0]       fifo_cnt_d   [MAX_OUTSTANDING];
    logic [31:0]      fifo_rdata_q [MAX_OUTSTANDING];
    logic [31:0]      fifo_rdata_d [MAX_OUTSTANDING];
`ifdef CV32E40P_OBI_RESP_ERR_EN
    logic             fifo_err_q   [MAX_OUTSTANDING];
    logic             fifo_err_d   [MAX_OUTSTANDING];
`endif

    logic [31:0]   ram [MEM_WORDS];
    logic [AW-1:0] idx_c;
    logic          oor_c;
    logic          stall_ok_c;
    logic          accept_c;
    logic          pop_c;
    logic          ram_we_c;
    logic [31:0]   rd_word_c;
    logic          unused_addr_c;

    assign idx_c = data_addr_i[AW+1:2];

    // Out-of-range decode only exists with the error feature; otherwise addresses alias.
`ifdef CV32E40P_OBI_RESP_ERR_EN
    assign oor_c         = |data_addr_i[31:AW+2];
    assign unused_addr_c = ^data_addr_i[1:0];
`else
    assign oor_c         = 1'b0;
    assign unused_addr_c = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
`endif

    generate
        if (GNT_DELAY == 0) begin : g_no_delay
            assign stall_ok_c = 1'b1;
        end else begin : g_delay
            assign stall_ok_c = (stall_cnt_q >= DELAY);
        end
    endgenerate

    // Full blocks grant even when the head pops this cycle.
    assign data_gnt_o = data_req_i && !rst_i && stall_ok_c && (out_cnt_q < MAX_CNT);
    assign accept_c   = data_req_i && data_gnt_o;
    assign pop_c      = !rst_i && (out_cnt_q != '0) && (fifo_cnt_q[head_q] == 4'd0);
    assign ram_we_c   = accept_c && data_we_i && !oor_c;
    assign rd_word_c  = oor_c ? 32'h0 : ram[idx_c];

    assign data_rvalid_o = pop_c;
    assign data_rdata_o  = pop_c ? fifo_rdata_q[head_q] : 32'h0;
`ifdef CV32E40P_OBI_RESP_ERR_EN
    assign data_err_o    = pop_c ? fifo_err_q[head_q] : 1'b0;
`endif

    // Next-state: stall counter, response countdowns, FIFO pointers, outstanding count.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        out_cnt_d    = out_cnt_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fifo_cnt_d   = fifo_cnt_q;
        fifo_rdata_d = fifo_rdata_q;
`ifdef CV32E40P_OBI_RESP_ERR_EN
        fifo_err_d   = fifo_err_q;
`endif

        if (!data_req_i || accept_c) begin
            stall_cnt_d = 4'd0;
        end else if (stall_cnt_q != 4'hF) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
        end

        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (fifo_cnt_q[i] != 4'd0) begin
                fifo_cnt_d[i] = fifo_cnt_q[i] - 4'd1;
            end
        end

        if (pop_c) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
        end

        if (accept_c) begin
            fifo_cnt_d[tail_q]   = LAT_INIT;
            fifo_rdata_d[tail_q] = data_we_i ? 32'h0 : rd_word_c;
`ifdef CV32E40P_OBI_RESP_ERR_EN
            fifo_err_d[tail_q]   = oor_c;
`endif
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
        end

        case ({accept_c, pop_c})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= 4'd0;
            out_cnt_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            fifo_cnt_q   <= '{default: 4'd0};
            fifo_rdata_q <= '{default: 32'h0};
`ifdef CV32E40P_OBI_RESP_ERR_EN
            fifo_err_q   <= '{default: 1'b0};
`endif
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            out_cnt_q    <= out_cnt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_rdata_q <= fifo_rdata_d;
`ifdef CV32E40P_OBI_RESP_ERR_EN
            fifo_err_q   <= fifo_err_d;
`endif
        end
    end

    // RAM is never reset; byte lanes written at the accept edge.
    always_ff @(posedge clk_i) begin
        if (ram_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    ram[idx_c][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule
